branch_resolve_queue: RTL and testbench
=======================================

// Module: branch_resolve_queue
// PURPOSE
//  Collects resolved-branch results from the branch FUs in execute and buffers them.
//  Issues one registered resolution per cycle to the branch stack as {resolve_bmm,
//  resolve_mispred}; resolve_target feeds fetch redirect.
//  Squashes buffered and incoming results that depend on a mispredicting branch.
//  Clears resolved bits from the dependency masks of surviving results.
// PARAMETERS
//  NUM_BR_FU     2   branch FUs reporting per cycle (lower index = older within a cycle)
//  BRQ_DEPTH     4   buffered results; must be >= NUM_BR_FU
//  B_MASK_WIDTH  4   branch-mask width; equals `B_MASK_WIDTH
//  ADDR_W        32  PC width
// PORTS
//  clock            in   1                     system clock
//  reset            in   1                     asynchronous, active-low reset
//  br_valid         in   NUM_BR_FU             FU i reports a resolved branch
//  br_bmm           in   NUM_BR_FU*B_MASK_W    one-hot mask bit owned by that branch
//  br_b_mask        in   NUM_BR_FU*B_MASK_W    older unresolved branches it depends on
//  br_mispred       in   NUM_BR_FU             1 = direction/target mispredicted
//  br_target        in   NUM_BR_FU*ADDR_W      correct next PC
//  br_ready         out  NUM_BR_FU             all-ones when >= NUM_BR_FU slots free, else all-zeros
//  resolve_valid    out  1                     broadcast valid this cycle
//  resolve_bmm      out  B_MASK_WIDTH          one-hot bit being resolved
//  resolve_mispred  out  1                     broadcast is a mispredict
//  resolve_target   out  ADDR_W                redirect PC, meaningful only when resolve_mispred
//  brq_count        out  $clog2(BRQ_DEPTH+1)   occupied entries (registered)
// BEHAVIOUR
//  - Reset (reset==0, async): queue emptied, brq_count=0, resolve_*=0, br_ready=all-ones.
//  - Storage: age-ordered compacting array; entry = {bmm, b_mask, mispred, target}; slot 0 is oldest.
//  - Broadcast: resolve_* are registered outputs. The value held in cycle t acts on cycle t:
//      - mispred=1: every queued or incoming entry with (b_mask & resolve_bmm)!=0 is dropped.
//        Dropped entries are neither enqueued nor selected.
//      - mispred=0: that bit is cleared in b_mask of all queued and incoming entries.
//  - Candidates in cycle t: surviving queued entries, then surviving incoming entries in FU index order.
//  - Selection in cycle t: one candidate chosen (see CONFIGURATION).
//    Its post-clear fields are registered into resolve_* at the end of cycle t.
//    Incoming-to-broadcast latency is 1 cycle, with bypass when the queue is empty.
//  - Remaining survivors are compacted and written back in age order.
//    New count = survivors - selected.
//  - br_ready is derived from the registered brq_count only: BRQ_DEPTH - brq_count >= NUM_BR_FU.
//  - br_valid while br_ready=0 is a protocol violation; the input is ignored and an assertion fires.
//  - No candidate: resolve_valid=0 and resolve_bmm/mispred/target=0 next cycle.
//  - A selected entry is never itself squashed by the same-cycle broadcast: it survived filtering.
//  - Back-to-back mispredicts: the second is visible only if it survived the first squash.
//  - Enqueue and dequeue in the same cycle are allowed; count never exceeds BRQ_DEPTH.
//  - Reset asserted mid-operation discards all entries immediately; no broadcast follows deassertion.
// CONFIGURATION
//  BRQ_MISPRED_PRIORITY_EN defined:
//    - selection = oldest surviving candidate with mispred=1, if any; otherwise oldest candidate.
//    - Younger correct-path results stay queued.
//  BRQ_MISPRED_PRIORITY_EN undefined:
//    - strict age order; always the oldest surviving candidate.
//    - A mispredict waits behind older correct resolutions.
// TESTING
//  1. Single correct branch, empty queue: br_valid=01, bmm=0001, b_mask=0000, mispred=0
//     -> next cycle resolve_valid=1, bmm=0001, mispred=0; brq_count stays 0.
//  2. Dependent squash: queue holds B (bmm=0010, b_mask=0001); broadcast bmm=0001, mispred=1,
//     target=0x1000 -> B dropped, brq_count 1->0, no later broadcast of 0010.
//  3. Mask clear: queue holds B (bmm=0100, b_mask=0011); broadcasts 0001 ok then 0010 ok
//     -> B broadcast with resolve_bmm=0100 in the third cycle.
//  4. Full: fill to brq_count=4 with no drain possible -> br_ready=00.
//     One broadcast drains to 3 -> br_ready stays 00 (free=1 < 2); at count=2 -> br_ready=11.
//  5. Priority (EN defined): queue A ok (0001), B mispred (0010) -> B broadcast first.
//     Undefined: A then B.
//  6. Reset pulse while brq_count=3 and resolve_valid=1 -> all outputs 0 asynchronously;
//     resolve_valid=0 on the first cycle after release.

Source files
------------

// File: rtl/branch_resolve_queue_if.sv
// Interface bundling the branch-FU report bus and the resolve broadcast bus
// of branch_resolve_queue. The master side is the execute stage / test driver,
// and the slave side is the queue itself.
interface branch_resolve_queue_if #(
    parameter int NUM_BR_FU    = 2,
    parameter int BRQ_DEPTH    = 4,
    parameter int B_MASK_WIDTH = 4,
    parameter int ADDR_W       = 32
);
    localparam int CW = $clog2(BRQ_DEPTH + 1);

    logic [NUM_BR_FU-1:0]              br_valid;
    logic [NUM_BR_FU*B_MASK_WIDTH-1:0] br_bmm;
    logic [NUM_BR_FU*B_MASK_WIDTH-1:0] br_b_mask;
    logic [NUM_BR_FU-1:0]              br_mispred;
    logic [NUM_BR_FU*ADDR_W-1:0]       br_target;
    logic [NUM_BR_FU-1:0]              br_ready;
    logic                              resolve_valid;
    logic [B_MASK_WIDTH-1:0]           resolve_bmm;
    logic                              resolve_mispred;
    logic [ADDR_W-1:0]                 resolve_target;
    logic [CW-1:0]                     brq_count;

    modport master (
        output br_valid, br_bmm, br_b_mask, br_mispred, br_target,
        input  br_ready, resolve_valid, resolve_bmm, resolve_mispred,
               resolve_target, brq_count
    );

    modport slave (
        input  br_valid, br_bmm, br_b_mask, br_mispred, br_target,
        output br_ready, resolve_valid, resolve_bmm, resolve_mispred,
               resolve_target, brq_count
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: buffers resolved-branch results from the branch FUs
// and broadcasts one registered resolution per cycle to the branch stack.
// The broadcast held in a cycle squashes dependents (mispredict) or clears its
// bit from dependency masks (correct) of both queued and incoming results.
// Optional feature: define BRQ_MISPRED_PRIORITY_EN to let the oldest surviving
// mispredict bypass older correct resolutions; otherwise strict age order.
module branch_resolve_queue #(
    parameter int NUM_BR_FU    = 2,
    parameter int BRQ_DEPTH    = 4,
    parameter int B_MASK_WIDTH = 4,
    parameter int ADDR_W       = 32
) (
    input logic                   clock,
    input logic                   reset,
    branch_resolve_queue_if.slave bus
);
    localparam int CW = $clog2(BRQ_DEPTH + 1);
    localparam int NC = BRQ_DEPTH + NUM_BR_FU;

`ifdef BRQ_MISPRED_PRIORITY_EN
    localparam int FIRST_PASS = 0;
`else
    localparam int FIRST_PASS = 1;
`endif

    logic [B_MASK_WIDTH-1:0] slotBmm_q  [BRQ_DEPTH];
    logic [B_MASK_WIDTH-1:0] slotMask_q [BRQ_DEPTH];
    logic                    slotMis_q  [BRQ_DEPTH];
    logic [ADDR_W-1:0]       slotTgt_q  [BRQ_DEPTH];
    logic [B_MASK_WIDTH-1:0] slotBmm_d  [BRQ_DEPTH];
    logic [B_MASK_WIDTH-1:0] slotMask_d [BRQ_DEPTH];
    logic                    slotMis_d  [BRQ_DEPTH];
    logic [ADDR_W-1:0]       slotTgt_d  [BRQ_DEPTH];
    logic [CW-1:0]           count_q, count_d;

    logic                    resValid_q, resValid_d;
    logic [B_MASK_WIDTH-1:0] resBmm_q, resBmm_d;
    logic                    resMis_q, resMis_d;
    logic [ADDR_W-1:0]       resTgt_q, resTgt_d;

    logic [B_MASK_WIDTH-1:0] cBmm  [NC];
    logic [B_MASK_WIDTH-1:0] cMask [NC];
    logic                    cMis  [NC];
    logic [ADDR_W-1:0]       cTgt  [NC];
    logic [NC-1:0]           cLive;
    logic [NC-1:0]           selOh;
    logic                    brReady;

    // Room for a full cycle of FU reports is judged from the registered count only.
    assign brReady = (count_q <= CW'(BRQ_DEPTH - NUM_BR_FU));

    assign bus.br_ready        = {NUM_BR_FU{brReady}};
    assign bus.resolve_valid   = resValid_q;
    assign bus.resolve_bmm     = resBmm_q;
    assign bus.resolve_mispred = resMis_q;
    assign bus.resolve_target  = resTgt_q;
    assign bus.brq_count       = count_q;

    // Line up queued entries (oldest first) then incoming reports, and apply this cycle's broadcast.
    always_comb begin : filterCandidates
        for (int i = 0; i < BRQ_DEPTH; i++) begin
            cBmm[i]  = slotBmm_q[i];
            cMask[i] = slotMask_q[i];
            cMis[i]  = slotMis_q[i];
            cTgt[i]  = slotTgt_q[i];
            cLive[i] = (CW'(i) < count_q);
        end
        for (int j = 0; j < NUM_BR_FU; j++) begin
            cBmm[BRQ_DEPTH+j]  = bus.br_bmm[j*B_MASK_WIDTH +: B_MASK_WIDTH];
            cMask[BRQ_DEPTH+j] = bus.br_b_mask[j*B_MASK_WIDTH +: B_MASK_WIDTH];
            cMis[BRQ_DEPTH+j]  = bus.br_mispred[j];
            cTgt[BRQ_DEPTH+j]  = bus.br_target[j*ADDR_W +: ADDR_W];
            cLive[BRQ_DEPTH+j] = bus.br_valid[j] & brReady;
        end
        for (int k = 0; k < NC; k++) begin
            if (resValid_q && resMis_q && (|(cMask[k] & resBmm_q))) begin
                cLive[k] = 1'b0;
            end
            if (resValid_q && !resMis_q) begin
                cMask[k] = cMask[k] & ~resBmm_q;
            end
        end
    end

    // Pick one survivor for the next broadcast and compact the rest back into the slots in age order.
    always_comb begin : selectAndCompact
        int wr;
        resValid_d = 1'b0;
        resBmm_d   = '0;
        resMis_d   = 1'b0;
        resTgt_d   = '0;
        selOh      = '0;
        for (int p = FIRST_PASS; p < 2; p++) begin
            for (int k = 0; k < NC; k++) begin
                if (!resValid_d && cLive[k] && (p == 1 || cMis[k])) begin
                    resValid_d = 1'b1;
                    selOh[k]   = 1'b1;
                    resBmm_d   = cBmm[k];
                    resMis_d   = cMis[k];
                    resTgt_d   = cTgt[k];
                end
            end
        end
        wr = 0;
        for (int i = 0; i < BRQ_DEPTH; i++) begin
            slotBmm_d[i]  = '0;
            slotMask_d[i] = '0;
            slotMis_d[i]  = 1'b0;
            slotTgt_d[i]  = '0;
        end
        for (int k = 0; k < NC; k++) begin
            if (cLive[k] && !selOh[k]) begin
                for (int i = 0; i < BRQ_DEPTH; i++) begin
                    if (i == wr) begin
                        slotBmm_d[i]  = cBmm[k];
                        slotMask_d[i] = cMask[k];
                        slotMis_d[i]  = cMis[k];
                        slotTgt_d[i]  = cTgt[k];
                    end
                end
                wr = wr + 1;
            end
        end
        count_d = CW'(wr);
    end

    // Register the queue contents and the broadcast; reset empties everything at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BRQ_DEPTH; i++) begin
                slotBmm_q[i]  <= '0;
                slotMask_q[i] <= '0;
                slotMis_q[i]  <= 1'b0;
                slotTgt_q[i]  <= '0;
            end
            count_q    <= '0;
            resValid_q <= 1'b0;
            resBmm_q   <= '0;
            resMis_q   <= 1'b0;
            resTgt_q   <= '0;
        end else begin
            for (int i = 0; i < BRQ_DEPTH; i++) begin
                slotBmm_q[i]  <= slotBmm_d[i];
                slotMask_q[i] <= slotMask_d[i];
                slotMis_q[i]  <= slotMis_d[i];
                slotTgt_q[i]  <= slotTgt_d[i];
            end
            count_q    <= count_d;
            resValid_q <= resValid_d;
            resBmm_q   <= resBmm_d;
            resMis_q   <= resMis_d;
            resTgt_q   <= resTgt_d;
        end
    end

    // Reports offered while the queue is not ready are dropped; flag them as a protocol error.
    brValidWhileNotReady: assert property (@(posedge clock) disable iff (!reset)
        !((|bus.br_valid) && !brReady));

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus
// randomized traffic, a queue-based reference model and a broadcast scoreboard.
module tb_branch_resolve_queue;
    localparam int NUM_BR_FU    = 2;
    localparam int BRQ_DEPTH    = 4;
    localparam int B_MASK_WIDTH = 4;
    localparam int ADDR_W       = 32;

    typedef struct packed {
        logic [3:0]  bmm;
        logic [3:0]  mask;
        logic        mis;
        logic [31:0] tgt;
    } entry_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  bmm;
        logic        mis;
        logic [31:0] tgt;
    } bcast_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    entry_t modelQ[$];
    bcast_t modelBc = '0;
    bcast_t expQ[$];
    int     checkCount = 0;
    int     passCount  = 0;
    bit     monitorOn  = 1'b0;

    branch_resolve_queue_if #(
        .NUM_BR_FU(NUM_BR_FU), .BRQ_DEPTH(BRQ_DEPTH),
        .B_MASK_WIDTH(B_MASK_WIDTH), .ADDR_W(ADDR_W)
    ) bus ();

    branch_resolve_queue #(
        .NUM_BR_FU(NUM_BR_FU), .BRQ_DEPTH(BRQ_DEPTH),
        .B_MASK_WIDTH(B_MASK_WIDTH), .ADDR_W(ADDR_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Reference model for one cycle: filter by the current broadcast, pick, keep the rest.
    task automatic modelStep(input logic [1:0] v, input entry_t e0, input entry_t e1);
        entry_t cand[$];
        entry_t surv[$];
        entry_t e;
        bcast_t nb;
        int     pick;
        cand = modelQ;
        if (v[0]) cand.push_back(e0);
        if (v[1]) cand.push_back(e1);
        foreach (cand[k]) begin
            e = cand[k];
            if (modelBc.valid && modelBc.mis && ((e.mask & modelBc.bmm) != 4'd0)) continue;
            if (modelBc.valid && !modelBc.mis) e.mask = e.mask & ~modelBc.bmm;
            surv.push_back(e);
        end
        pick = -1;
`ifdef BRQ_MISPRED_PRIORITY_EN
        foreach (surv[k]) if (pick < 0 && surv[k].mis) pick = k;
`endif
        if (pick < 0 && surv.size() > 0) pick = 0;
        nb = '0;
        if (pick >= 0) begin
            nb.valid = 1'b1;
            nb.bmm   = surv[pick].bmm;
            nb.mis   = surv[pick].mis;
            nb.tgt   = surv[pick].tgt;
            surv.delete(pick);
            expQ.push_back(nb);
        end
        modelQ  = surv;
        modelBc = nb;
    endtask

    task automatic driveIdleInputs();
        bus.br_valid   = '0;
        bus.br_bmm     = '0;
        bus.br_b_mask  = '0;
        bus.br_mispred = '0;
        bus.br_target  = '0;
    endtask

    // One clock of stimulus: check registered status, drive reports, advance the model.
    task automatic applyStimulus(input logic [1:0] vIn, input entry_t e0, input entry_t e1);
        logic [1:0] v;
        bit         ready;
        @(posedge clock);
        #1;
        ready = (BRQ_DEPTH - modelQ.size()) >= NUM_BR_FU;
        checkOutput("brq_count", 64'(bus.brq_count), 64'(modelQ.size()));
        checkOutput("br_ready", 64'(bus.br_ready), ready ? 64'h3 : 64'h0);
        v = ready ? vIn : 2'b00;
        bus.br_valid   = v;
        bus.br_bmm     = {e1.bmm, e0.bmm};
        bus.br_b_mask  = {e1.mask, e0.mask};
        bus.br_mispred = {e1.mis, e0.mis};
        bus.br_target  = {e1.tgt, e0.tgt};
        modelStep(v, e0, e1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, '0, '0);
    endtask

    function automatic entry_t randEntry();
        entry_t e;
        e.bmm  = 4'b0001 << $urandom_range(0, 3);
        e.mask = 4'($urandom) & ~e.bmm;
        e.mis  = ($urandom_range(0, 3) == 0);
        e.tgt  = $urandom;
        return e;
    endfunction

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'($urandom_range(0, 3)), randEntry(), randEntry());
    endtask

    // Scoreboard monitor: compare each presented broadcast with the oldest expected one.
    initial begin
        bcast_t e;
        forever begin
            @(negedge clock);
            if (monitorOn) begin
                if (bus.resolve_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_resolve_valid", 64'(bus.resolve_valid), 64'h0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("resolve_bmm", 64'(bus.resolve_bmm), 64'(e.bmm));
                        checkOutput("resolve_mispred", 64'(bus.resolve_mispred), 64'(e.mis));
                        if (e.mis) checkOutput("resolve_target", 64'(bus.resolve_target), 64'(e.tgt));
                    end
                end else begin
                    checkOutput("idle_resolve_bmm", 64'(bus.resolve_bmm), 64'h0);
                    checkOutput("idle_resolve_mispred", 64'(bus.resolve_mispred), 64'h0);
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_resolve_valid"}, 64'(bus.resolve_valid), 64'h0);
        checkOutput({tag, "_resolve_bmm"}, 64'(bus.resolve_bmm), 64'h0);
        checkOutput({tag, "_resolve_mispred"}, 64'(bus.resolve_mispred), 64'h0);
        checkOutput({tag, "_resolve_target"}, 64'(bus.resolve_target), 64'h0);
        checkOutput({tag, "_brq_count"}, 64'(bus.brq_count), 64'h0);
        checkOutput({tag, "_br_ready"}, 64'(bus.br_ready), 64'h3);
    endtask

    initial begin
        int tries;
        driveIdleInputs();
        #12;
        checkResetOutputs("por");
        #5;
        reset     = 1'b1;
        monitorOn = 1'b1;

        // Single correct branch on an empty queue
        applyStimulus(2'b01, '{bmm: 4'b0001, mask: 4'b0000, mis: 1'b0, tgt: 32'h100}, '0);
        idleCycles(3);

        // Mispredict squashes its dependent
        applyStimulus(2'b11, '{bmm: 4'b0001, mask: 4'b0000, mis: 1'b1, tgt: 32'h1000},
                             '{bmm: 4'b0010, mask: 4'b0001, mis: 1'b0, tgt: 32'h2000});
        idleCycles(3);

        // Successive correct broadcasts clear both dependency bits
        applyStimulus(2'b11, '{bmm: 4'b0001, mask: 4'b0000, mis: 1'b0, tgt: 32'h10},
                             '{bmm: 4'b0010, mask: 4'b0001, mis: 1'b0, tgt: 32'h20});
        applyStimulus(2'b01, '{bmm: 4'b0100, mask: 4'b0011, mis: 1'b0, tgt: 32'h30}, '0);
        idleCycles(3);

        // Older correct result and younger mispredict in the same cycle
        applyStimulus(2'b11, '{bmm: 4'b0001, mask: 4'b0000, mis: 1'b0, tgt: 32'h40},
                             '{bmm: 4'b0010, mask: 4'b0000, mis: 1'b1, tgt: 32'h50});
        idleCycles(3);

        // Fill the queue until back-pressure
        for (int i = 0; i < 6; i++)
            applyStimulus(2'b11, '{bmm: 4'b0001, mask: 4'b0000, mis: 1'b0, tgt: 32'(i)},
                                 '{bmm: 4'b0010, mask: 4'b0000, mis: 1'b0, tgt: 32'(i + 8)});
        idleCycles(5);

        randomCycles(300);

        // Asynchronous reset with a busy queue and a live broadcast
        tries = 0;
        while (tries < 200 && !(modelQ.size() == 3 && modelBc.valid)) begin
            applyStimulus(2'b11, randEntry(), randEntry());
            tries++;
        end
        #3;
        monitorOn = 1'b0;
        driveIdleInputs();
        reset = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        @(posedge clock);
        #3;
        reset = 1'b1;
        modelQ.delete();
        modelBc = '0;
        expQ.delete();
        monitorOn = 1'b1;
        @(negedge clock);
        #1;
        checkOutput("post_reset_resolve_valid", 64'(bus.resolve_valid), 64'h0);

        randomCycles(300);
        idleCycles(8);
        checkOutput("pending_broadcasts", 64'(expQ.size()), 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
